// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the register bank, ID/EX and EX/MEM stages.
package pipe_pkg;

    localparam int XLEN  = 64;
    localparam int RADDR = 5;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = 8'h00;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector; shared with the decode stall logic.
module load_use_detect #(
    parameter int RADDR = pipe_pkg::RADDR
) (
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [RADDR-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    output logic             hazard_stall
);

    always_comb begin
        hazard_stall = ex_valid && ex_memread && id_valid && (ex_rd != '0)
                       && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional write-back bypass of the register-bank read data: define IDEX_WB_BYPASS_EN.
module id_ex_stage #(
    parameter int XLEN  = pipe_pkg::XLEN,
    parameter int RADDR = pipe_pkg::RADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RADDR-1:0]  id_rs1,
    input  logic [RADDR-1:0]  id_rs2,
    input  logic [RADDR-1:0]  id_rd,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  pipe_pkg::ctrl_t   id_ctrl,
    input  logic              wb_regwrite,
    input  logic [RADDR-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [RADDR-1:0]  ex_rs1,
    output logic [RADDR-1:0]  ex_rs2,
    output logic [RADDR-1:0]  ex_rd,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,
    output pipe_pkg::ctrl_t   ex_ctrl,
    output logic              hazard_stall,
    output logic [31:0]       stall_count
);

    import pipe_pkg::*;

    logic             valid_q, valid_d;
    logic [RADDR-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic [XLEN-1:0]  imm_q, imm_d, pc_q, pc_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [31:0]      stall_count_q, stall_count_d;
    logic [XLEN-1:0]  op1, op2;

    load_use_detect #(.RADDR(RADDR)) u_load_use_detect (
        .ex_valid     (valid_q),
        .ex_memread   (ctrl_q.memread),
        .ex_rd        (rd_q),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .hazard_stall (hazard_stall)
    );

    // x0 is forced last so it overrides any write-back bypass.
    always_comb begin
        op1 = id_rdata1;
        op2 = id_rdata2;
`ifdef IDEX_WB_BYPASS_EN
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) op1 = wb_data;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) op2 = wb_data;
`endif
        if (id_rs1 == '0) op1 = '0;
        if (id_rs2 == '0) op2 = '0;
    end

`ifndef IDEX_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};
`endif

    always_comb begin
        valid_d       = valid_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        rdata1_d      = rdata1_q;
        rdata2_d      = rdata2_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        ctrl_d        = ctrl_q;
        stall_count_d = stall_count_q;
        if (ex_flush || hazard_stall) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            if (!ex_flush) stall_count_d = stall_count_q + 32'd1;
        end else begin
            valid_d  = id_valid;
            rs1_d    = id_rs1;
            rs2_d    = id_rs2;
            rd_d     = id_rd;
            rdata1_d = op1;
            rdata2_d = op2;
            imm_d    = id_imm;
            pc_d     = id_pc;
            ctrl_d   = id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            ctrl_q        <= CTRL_BUBBLE;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            rdata1_q      <= rdata1_d;
            rdata2_q      <= rdata2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            ctrl_q        <= ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign ex_pc       = pc_q;
    assign ex_ctrl     = ctrl_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan steps then randomized cycles
// against a behavioural model of the stage.
module tb_id_ex_stage;
   import pipe_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic [63:0]       id_rdata1, id_rdata2, id_imm, id_pc;
   ctrl_t             id_ctrl;
   logic              wb_regwrite;
   logic [4:0]        wb_rd;
   logic [63:0]       wb_data;
   logic              ex_flush;
   logic              ex_valid;
   logic [4:0]        ex_rs1, ex_rs2, ex_rd;
   logic [63:0]       ex_rdata1, ex_rdata2, ex_imm, ex_pc;
   ctrl_t             ex_ctrl;
   logic              hazard_stall;
   logic [31:0]       stall_count;

   int checks = 0;
   int failures = 0;

   // Behavioural view of what execute should be seeing
   bit                mValid;
   bit                mKnown;
   logic [4:0]        mRs1, mRs2, mRd;
   logic [63:0]       mRdata1, mRdata2, mImm, mPc;
   logic [7:0]        mCtrl;
   logic [31:0]       mCount;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc(id_pc),
      .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
      .ex_pc(ex_pc), .ex_ctrl(ex_ctrl), .hazard_stall(hazard_stall),
      .stall_count(stall_count)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Value an operand should carry: x0 is zero, optional write-back bypass next
   function automatic logic [63:0] operandValue(input logic [4:0] rs, input logic [63:0] bank);
      if (rs == 5'd0) return 64'd0;
`ifdef IDEX_WB_BYPASS_EN
      if (wb_regwrite && wb_rd == rs) return wb_data;
`endif
      return bank;
   endfunction

   // Checks the stall output, advances one clock, updates the model and checks execute outputs
   task automatic applyStimulus(input string tag);
      bit hazard;
      #1;
      hazard = mValid && mCtrl[6] && id_valid && (mRd != 5'd0)
               && (mRd == id_rs1 || mRd == id_rs2);
      checkOutput({tag, ".hazard_stall"}, 64'(hazard_stall), 64'(hazard));
      if (reset) begin
         mValid = 0; mKnown = 1; mCtrl = 8'h00; mCount = 32'd0;
         mRs1 = 5'd0; mRs2 = 5'd0; mRd = 5'd0;
         mRdata1 = 64'd0; mRdata2 = 64'd0; mImm = 64'd0; mPc = 64'd0;
      end else if (ex_flush || hazard) begin
         mValid = 0; mKnown = 0; mCtrl = 8'h00;
         if (!ex_flush) mCount = mCount + 32'd1;
      end else begin
         mValid = id_valid; mKnown = 1; mCtrl = id_ctrl;
         mRs1 = id_rs1; mRs2 = id_rs2; mRd = id_rd;
         mRdata1 = operandValue(id_rs1, id_rdata1);
         mRdata2 = operandValue(id_rs2, id_rdata2);
         mImm = id_imm; mPc = id_pc;
      end
      @(posedge clk);
      #1;
      checkOutput({tag, ".ex_valid"}, 64'(ex_valid), 64'(mValid));
      checkOutput({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(mCtrl));
      checkOutput({tag, ".stall_count"}, 64'(stall_count), 64'(mCount));
      if (mKnown) begin
         checkOutput({tag, ".ex_rs1"}, 64'(ex_rs1), 64'(mRs1));
         checkOutput({tag, ".ex_rs2"}, 64'(ex_rs2), 64'(mRs2));
         checkOutput({tag, ".ex_rd"}, 64'(ex_rd), 64'(mRd));
         checkOutput({tag, ".ex_rdata1"}, ex_rdata1, mRdata1);
         checkOutput({tag, ".ex_rdata2"}, ex_rdata2, mRdata2);
         checkOutput({tag, ".ex_imm"}, ex_imm, mImm);
         checkOutput({tag, ".ex_pc"}, ex_pc, mPc);
      end
      @(negedge clk);
   endtask

   task automatic idleInputs();
      reset = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_pc = 0; id_ctrl = 8'h00;
      wb_regwrite = 0; wb_rd = 0; wb_data = 0; ex_flush = 0;
   endtask

   // Places a load (LDUR) writing rd into the execute slot
   task automatic issueLoad(input logic [4:0] rd, input string tag);
      idleInputs();
      id_valid = 1; id_rd = rd; id_rs1 = 5'd9; id_rs2 = 5'd10; id_pc = 64'h100;
      id_ctrl = 8'b1101_0000;
      applyStimulus(tag);
   endtask

   initial begin
      mValid = 0; mKnown = 0; mCtrl = 8'h00; mCount = 32'd0;
      mRs1 = 0; mRs2 = 0; mRd = 0; mRdata1 = 0; mRdata2 = 0; mImm = 0; mPc = 0;
      idleInputs();
      reset = 1;
      @(negedge clk);
      applyStimulus("reset");
      checkOutput("reset.ex_valid_const", 64'(ex_valid), 64'd0);

      idleInputs();
      id_valid = 1; id_rs1 = 5'd3; id_rdata1 = 64'h1234; id_imm = -64'sd8; id_pc = 64'h40;
      applyStimulus("capture");
      checkOutput("capture.imm_const", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      checkOutput("capture.rdata1_const", ex_rdata1, 64'h1234);

      issueLoad(5'd5, "load5");
      idleInputs();
      id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd6; id_pc = 64'h104;
      id_ctrl = 8'b1000_0010; id_rdata2 = 64'h55;
      applyStimulus("loaduse_stall");
      checkOutput("loaduse.count_const", 64'(stall_count), 64'd1);
      applyStimulus("loaduse_retry");
      checkOutput("loaduse.retry_valid_const", 64'(ex_valid), 64'd1);

      issueLoad(5'd0, "load0");
      idleInputs();
      id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd0;
      applyStimulus("nohazard_x0");
      issueLoad(5'd4, "load4");
      idleInputs();
      id_valid = 0; id_rs1 = 5'd4;
      applyStimulus("nohazard_invalid");

      issueLoad(5'd6, "load6");
      idleInputs();
      id_valid = 1; id_rs1 = 5'd6; ex_flush = 1;
      applyStimulus("flush_vs_stall");
      checkOutput("flush.count_const", 64'(stall_count), 64'd1);

      idleInputs();
      id_valid = 1; id_rs1 = 5'd0; id_rdata1 = 64'hDEAD;
      id_rs2 = 5'd7; id_rdata2 = 64'h11;
      wb_regwrite = 1; wb_rd = 5'd7; wb_data = 64'hAA;
      applyStimulus("zero_bypass");
      checkOutput("zero.rdata1_const", ex_rdata1, 64'd0);
`ifdef IDEX_WB_BYPASS_EN
      checkOutput("bypass.rdata2_const", ex_rdata2, 64'hAA);
`else
      checkOutput("bypass.rdata2_const", ex_rdata2, 64'h11);
`endif

      for (int i = 0; i < 400; i++) begin
         id_valid = ($urandom_range(0, 9) != 0);
         id_rs1 = 5'($urandom_range(0, 7));
         id_rs2 = 5'($urandom_range(0, 7));
         id_rd = 5'($urandom_range(0, 7));
         id_rdata1 = {$urandom, $urandom};
         id_rdata2 = {$urandom, $urandom};
         id_imm = {$urandom, $urandom};
         id_pc = {$urandom, $urandom};
         id_ctrl = 8'($urandom);
         if ($urandom_range(0, 2) == 0) id_ctrl.memread = 1'b1;
         wb_regwrite = 1'($urandom_range(0, 1));
         wb_rd = 5'($urandom_range(0, 7));
         wb_data = {$urandom, $urandom};
         ex_flush = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 79) == 0);
         applyStimulus("random");
      end

      idleInputs();
      id_valid = 1; id_rs1 = 5'd2; id_rd = 5'd3; id_pc = 64'h200; id_ctrl = 8'b1000_0000;
      applyStimulus("prereset");
      reset = 1;
      applyStimulus("midreset");
      checkOutput("midreset.count_const", 64'(stall_count), 64'd0);
      checkOutput("midreset.valid_const", 64'(ex_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
